// File: rtl/traffic_pkg.sv
// Shared types for the intersection controller: phase codes, timer sub-states,
// lamp encodings and the timer duration width.
package traffic_pkg;

  localparam int DUR_W = 16;

  typedef logic [DUR_W-1:0] dur_t;

  typedef enum logic [3:0] {
    PH_START     = 4'd0,
    PH_NS_GREEN  = 4'd1,
    PH_NS_YELLOW = 4'd2,
    PH_NS_CLEAR  = 4'd3,
    PH_EW_GREEN  = 4'd4,
    PH_EW_YELLOW = 4'd5,
    PH_EW_CLEAR  = 4'd6,
    PH_WALK      = 4'd7,
    PH_FLASH     = 4'd8
  } phase_e;

  typedef enum logic [1:0] {
    SUB_LOAD = 2'd0,
    SUB_ARM  = 2'd1,
    SUB_RUN  = 2'd2
  } sub_e;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;
  localparam logic [2:0] LIGHT_OFF = 3'b000;

  // Fixed ring order; WALK and FLASH are entered by side conditions only.
  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    n = PH_START;
    case (p)
      PH_START:     n = PH_NS_GREEN;
      PH_NS_GREEN:  n = PH_NS_YELLOW;
      PH_NS_YELLOW: n = PH_NS_CLEAR;
      PH_NS_CLEAR:  n = PH_EW_GREEN;
      PH_EW_GREEN:  n = PH_EW_YELLOW;
      PH_EW_YELLOW: n = PH_EW_CLEAR;
      PH_EW_CLEAR:  n = PH_NS_GREEN;
      default:      n = PH_START;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ped_request_latch.sv
// Pedestrian request latch: set by the button, cleared when the walk phase
// is loaded or while flashing. Clear dominates set.
module ped_request_latch (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic set_i,
  input  logic clr_i,
  output logic req_o
);

  logic req_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q <= 1'b0;
    end else if (clr_i) begin
      req_q <= 1'b0;
    end else if (set_i) begin
      req_q <= 1'b1;
    end
  end

  assign req_o = req_q;

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Phase sequencer driving time_fsm and the lamps. Optional pedestrian walk
// phase is built when PED_REQUEST_EN is defined.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter logic [DUR_W-1:0] T_GREEN_NS = 16'd30,
  parameter logic [DUR_W-1:0] T_GREEN_EW = 16'd25,
  parameter logic [DUR_W-1:0] T_YELLOW   = 16'd3,
  parameter logic [DUR_W-1:0] T_CLEAR    = 16'd2,
  parameter logic [DUR_W-1:0] T_WALK     = 16'd10
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             flash,
  input  logic             ped_req,
  input  logic             tmr_finished,
  output logic             tmr_enable,
  output logic             tmr_reset,
  output logic [DUR_W-1:0] tmr_seconds,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             ped_walk,
  output logic [3:0]       phase
);

  phase_e phase_q, phase_d;
  sub_e   sub_q, sub_d;
  phase_e ret_q, ret_d;
  logic   started_q;
  logic   flash_on_q, flash_on_d;
  logic   walk_pending;

  logic             tmr_enable_q;
  logic             tmr_reset_q;
  dur_t             tmr_seconds_q;
  logic [2:0]       ns_q, ns_d;
  logic [2:0]       ew_q, ew_d;

  function automatic dur_t dur_of(input phase_e p);
    dur_t d;
    d = T_CLEAR;
    case (p)
      PH_NS_GREEN:               d = T_GREEN_NS;
      PH_EW_GREEN:               d = T_GREEN_EW;
      PH_NS_YELLOW, PH_EW_YELLOW: d = T_YELLOW;
      PH_WALK:                   d = T_WALK;
      PH_FLASH:                  d = 16'd1;
      default:                   d = T_CLEAR;
    endcase
    return d;
  endfunction

  // Phase/sub-state next-state logic. Flash level changes beat timer expiry.
  always_comb begin
    phase_d    = phase_q;
    sub_d      = sub_q;
    ret_d      = ret_q;
    flash_on_d = flash_on_q;
    if (!started_q) begin
      phase_d = PH_START;
      sub_d   = SUB_LOAD;
    end else if (flash && (phase_q != PH_FLASH)) begin
      phase_d    = PH_FLASH;
      sub_d      = SUB_LOAD;
      flash_on_d = 1'b1;
    end else if (!flash && (phase_q == PH_FLASH)) begin
      phase_d = PH_START;
      sub_d   = SUB_LOAD;
    end else begin
      case (sub_q)
        SUB_LOAD: sub_d = SUB_ARM;
        // The timer reports finished during its own reset cycle; skip it.
        SUB_ARM:  sub_d = SUB_RUN;
        default: begin
          if (tmr_finished) begin
            sub_d = SUB_LOAD;
            case (phase_q)
              PH_FLASH: flash_on_d = !flash_on_q;
              PH_NS_CLEAR, PH_EW_CLEAR: begin
                if (walk_pending) begin
                  phase_d = PH_WALK;
                  ret_d   = next_phase(phase_q);
                end else begin
                  phase_d = next_phase(phase_q);
                end
              end
              PH_WALK:  phase_d = ret_q;
              default:  phase_d = next_phase(phase_q);
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    ns_d = LIGHT_RED;
    ew_d = LIGHT_RED;
    case (phase_d)
      PH_NS_GREEN:  ns_d = LIGHT_GRN;
      PH_NS_YELLOW: ns_d = LIGHT_YEL;
      PH_EW_GREEN:  ew_d = LIGHT_GRN;
      PH_EW_YELLOW: ew_d = LIGHT_YEL;
      PH_FLASH: begin
        ns_d = flash_on_d ? LIGHT_YEL : LIGHT_OFF;
        ew_d = flash_on_d ? LIGHT_YEL : LIGHT_OFF;
      end
      default: ;
    endcase
  end

  // Outputs are registered from the state being entered so they stay aligned
  // with phase_q; the reset state shows all-red with the timer idle.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      started_q     <= 1'b0;
      phase_q       <= PH_START;
      sub_q         <= SUB_LOAD;
      ret_q         <= PH_NS_GREEN;
      flash_on_q    <= 1'b1;
      tmr_enable_q  <= 1'b0;
      tmr_reset_q   <= 1'b0;
      tmr_seconds_q <= '0;
      ns_q          <= LIGHT_RED;
      ew_q          <= LIGHT_RED;
    end else begin
      started_q     <= 1'b1;
      phase_q       <= phase_d;
      sub_q         <= sub_d;
      ret_q         <= ret_d;
      flash_on_q    <= flash_on_d;
      tmr_enable_q  <= 1'b1;
      tmr_reset_q   <= (sub_d == SUB_LOAD);
      tmr_seconds_q <= dur_of(phase_d);
      ns_q          <= ns_d;
      ew_q          <= ew_d;
    end
  end

`ifdef PED_REQUEST_EN
  logic ped_clr;
  logic walk_q;

  assign ped_clr = ((phase_q == PH_WALK) && (sub_q == SUB_LOAD)) || (phase_q == PH_FLASH);

  ped_request_latch u_ped_latch (
    .clk_i  (CLK),
    .rst_ni (reset),
    .set_i  (ped_req),
    .clr_i  (ped_clr),
    .req_o  (walk_pending)
  );

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      walk_q <= 1'b0;
    end else begin
      walk_q <= (phase_d == PH_WALK);
    end
  end

  assign ped_walk = walk_q;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
  assign walk_pending   = 1'b0;
  assign ped_walk       = 1'b0;
`endif

  assign tmr_enable  = tmr_enable_q;
  assign tmr_reset   = tmr_reset_q;
  assign tmr_seconds = tmr_seconds_q;
  assign ns_light    = ns_q;
  assign ew_light    = ew_q;
  assign phase       = phase_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer; the bench drives tmr_finished
// itself in place of time_fsm. A second instance runs with a zero yellow time.
module tb_traffic_phase_sequencer;

  localparam int P_START = 0, P_NSG = 1, P_NSY = 2, P_NSC = 3;
  localparam int P_EWG = 4, P_EWY = 5, P_EWC = 6, P_WALK = 7, P_FLASH = 8;
  localparam int RED = 4, YEL = 2, GRN = 1, OFF = 0;

  logic        CLK = 1'b0;
  logic        reset;
  logic        flash;
  logic        ped_req;
  logic        tmr_finished;

  logic        tmr_enable, tmr_reset, ped_walk;
  logic [15:0] tmr_seconds;
  logic [2:0]  ns_light, ew_light;
  logic [3:0]  phase;

  logic        y0_enable, y0_reset, y0_walk;
  logic [15:0] y0_seconds;
  logic [2:0]  y0_ns, y0_ew;
  logic [3:0]  y0_phase;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  traffic_phase_sequencer #(
    .T_GREEN_NS(16'd2), .T_GREEN_EW(16'd2), .T_YELLOW(16'd1),
    .T_CLEAR(16'd1), .T_WALK(16'd1)
  ) u_dut (
    .CLK(CLK), .reset(reset), .flash(flash), .ped_req(ped_req),
    .tmr_finished(tmr_finished), .tmr_enable(tmr_enable), .tmr_reset(tmr_reset),
    .tmr_seconds(tmr_seconds), .ns_light(ns_light), .ew_light(ew_light),
    .ped_walk(ped_walk), .phase(phase)
  );

  traffic_phase_sequencer #(
    .T_GREEN_NS(16'd2), .T_GREEN_EW(16'd2), .T_YELLOW(16'd0),
    .T_CLEAR(16'd1), .T_WALK(16'd1)
  ) u_dut_y0 (
    .CLK(CLK), .reset(reset), .flash(flash), .ped_req(ped_req),
    .tmr_finished(tmr_finished), .tmr_enable(y0_enable), .tmr_reset(y0_reset),
    .tmr_seconds(y0_seconds), .ns_light(y0_ns), .ew_light(y0_ew),
    .ped_walk(y0_walk), .phase(y0_phase)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".ph"},  16'(phase), 16'd0);
    check({tag, ".en"},  16'(tmr_enable), 16'd0);
    check({tag, ".rst"}, 16'(tmr_reset), 16'd0);
    check({tag, ".sec"}, tmr_seconds, 16'd0);
    check({tag, ".ns"},  16'(ns_light), 16'(RED));
    check({tag, ".ew"},  16'(ew_light), 16'(RED));
    check({tag, ".walk"}, 16'(ped_walk), 16'd0);
    check({tag, ".y0ph"}, 16'(y0_phase), 16'd0);
  endtask

  // Called with the DUT about to show the LOAD cycle of a phase. Raises
  // tmr_finished during ARM (must be ignored) and again in the last of
  // run_len RUN cycles; returns with that expiry about to be sampled.
  task automatic expect_phase(input string tag, input int ph, input int secs,
                              input int ns, input int ew, input int walk,
                              input int run_len, input logic ped);
    int y0_secs;
    y0_secs = (ph == P_NSY || ph == P_EWY) ? 0 : secs;
    @(negedge CLK);
    check({tag, ".ph"},   16'(phase), 16'(ph));
    check({tag, ".sec"},  tmr_seconds, 16'(secs));
    check({tag, ".load"}, {14'd0, tmr_enable, tmr_reset}, 16'd3);
    check({tag, ".ns"},   16'(ns_light), 16'(ns));
    check({tag, ".ew"},   16'(ew_light), 16'(ew));
    check({tag, ".walk"}, 16'(ped_walk), 16'(walk));
    check({tag, ".y0ph"}, 16'(y0_phase), 16'(ph));
    check({tag, ".y0sec"}, y0_seconds, 16'(y0_secs));
    tmr_finished = 1'b0;
    @(negedge CLK);
    check({tag, ".arm"},    {14'd0, tmr_enable, tmr_reset}, 16'd2);
    check({tag, ".armsec"}, tmr_seconds, 16'(secs));
    tmr_finished = 1'b1;
    ped_req = ped;
    for (int i = 0; i < run_len; i++) begin
      @(negedge CLK);
      check({tag, ".runph"},  16'(phase), 16'(ph));
      check({tag, ".runrst"}, {14'd0, tmr_enable, tmr_reset}, 16'd2);
      ped_req = 1'b0;
      tmr_finished = (i == run_len - 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    flash = 1'b0;
    ped_req = 1'b0;
    tmr_finished = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_values("rst0");
    reset = 1'b1;

    // Free-running ring with exact durations and lamp codes.
    expect_phase("start", P_START, 1, RED, RED, 0, 2, 1'b0);
    expect_phase("nsg",   P_NSG,   2, GRN, RED, 0, 3, 1'b0);
    expect_phase("nsy",   P_NSY,   1, YEL, RED, 0, 1, 1'b0);
    expect_phase("nsc",   P_NSC,   1, RED, RED, 0, 1, 1'b0);
    expect_phase("ewg",   P_EWG,   2, RED, GRN, 0, 2, 1'b1);
    expect_phase("ewy",   P_EWY,   1, RED, YEL, 0, 1, 1'b0);
    expect_phase("ewc",   P_EWC,   1, RED, RED, 0, 2, 1'b0);
`ifdef PED_REQUEST_EN
    expect_phase("walk",  P_WALK,  1, RED, RED, 1, 1, 1'b0);
`endif
    expect_phase("nsg2",  P_NSG,   2, GRN, RED, 0, 2, 1'b0);

    // Flash rising together with an expiry in NS green: flash wins.
    flash = 1'b1;
    expect_phase("fl1", P_FLASH, 1, YEL, YEL, 0, 1, 1'b0);
    expect_phase("fl2", P_FLASH, 1, OFF, OFF, 0, 2, 1'b0);
    expect_phase("fl3", P_FLASH, 1, YEL, YEL, 0, 1, 1'b0);
    flash = 1'b0;
    expect_phase("start2", P_START, 1, RED, RED, 0, 1, 1'b0);
    expect_phase("nsg3",   P_NSG,   2, GRN, RED, 0, 1, 1'b0);
    expect_phase("nsy3",   P_NSY,   1, YEL, RED, 0, 1, 1'b0);
    expect_phase("nsc3",   P_NSC,   1, RED, RED, 0, 1, 1'b0);
    expect_phase("ewg3",   P_EWG,   2, RED, GRN, 0, 1, 1'b0);

    // Asynchronous reset in the middle of EW yellow.
    @(negedge CLK);
    check("ewy3.ph", 16'(phase), 16'(P_EWY));
    check("ewy3.ew", 16'(ew_light), 16'(YEL));
    tmr_finished = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_values("rst1");
    @(negedge CLK);
    check_reset_values("rst1b");
    reset = 1'b1;
    expect_phase("start3", P_START, 1, RED, RED, 0, 1, 1'b0);
    expect_phase("nsg4",   P_NSG,   2, GRN, RED, 0, 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Phase sequencer for the two-way intersection controller. Walks the light cycle and drives the lamp outputs. Sits directly upstream of `time_fsm`:
- For each phase it loads the phase duration into the timer, enables it, and advances when the timer's `finished` flag reports expiry.
- Adds a night-flash mode and an optional pedestrian walk phase.

## Interface
Parameters:
- `T_GREEN_NS`, 30: north-south green duration, seconds (16 bit).
- `T_GREEN_EW`, 25: east-west green duration, seconds.
- `T_YELLOW`, 3: yellow duration, seconds.
- `T_CLEAR`, 2: all-red clearance duration, seconds.
- `T_WALK`, 10: pedestrian walk duration, seconds (used only with `PED_REQUEST_EN`).

Ports:
- `CLK` in 1: 10 kHz system clock, shared with `time_fsm`.
- `reset` in 1: asynchronous, active-low reset; single clock domain.
- `flash` in 1: night mode request, level, synchronous to `CLK`.
- `ped_req` in 1: pedestrian button, already synchronised. Held high 1+ cycles.
- `tmr_finished` in 1: `finished` output of `time_fsm`.
- `tmr_enable` out 1: to `time_fsm.enable`.
- `tmr_reset` out 1: to `time_fsm.reset` (active-high at the timer).
- `tmr_seconds` out 16: to `time_fsm.secondsToCount`.
- `ns_light` out 3: {red, yellow, green}, one-hot or all-off.
- `ew_light` out 3: {red, yellow, green}.
- `ped_walk` out 1: walk lamp.
- `phase` out 4: current phase code, for debug.

## Operation
- Phases, in order: `START` (all red, `T_CLEAR`) -> `NS_GREEN` -> `NS_YELLOW` -> `NS_CLEAR` -> `EW_GREEN` -> `EW_YELLOW` -> `EW_CLEAR` -> `NS_GREEN`.
- Other phases:
  - `WALK`: all red, `ped_walk`=1.
  - `FLASH`: lamps per the flash rule below.
- Lamps in each phase:
  - GREEN/YELLOW phases: the named direction shows green/yellow; the other direction shows red.
  - CLEAR, START and WALK: both directions red (3'b100).
- Each phase runs three sub-states:
  - `LOAD`, 1 cycle: `tmr_enable`=1, `tmr_reset`=1, `tmr_seconds`=phase duration.
  - `ARM`, 1 cycle: `tmr_enable`=1, `tmr_reset`=0. `tmr_finished` is ignored here, because the timer raises `finished` during its reset cycle.
  - `RUN`: `tmr_enable`=1 and `tmr_reset`=0 until `tmr_finished`=1. The next phase's `LOAD` follows in the next cycle.
- `tmr_seconds` holds the current phase duration throughout `ARM` and `RUN`.
- `flash`=1, sampled in any sub-state of any phase: the next cycle enters `FLASH`/`LOAD` with duration 1.
  - In `FLASH`, `ns_light` and `ew_light` both show yellow (3'b010) and all-off (3'b000) on alternate timer expiries. Yellow comes first.
  - `flash` falling: the next cycle enters `START`/`LOAD`.
- A zero duration parameter is legal. The timer expires after the next `ARM`, so the phase lasts about 3 cycles.

## Timing
- Reset (asynchronous assert) forces:
  - state `START`/`LOAD`;
  - `ns_light`=`ew_light`=3'b100;
  - `tmr_enable`=0, `tmr_reset`=0, `tmr_seconds`=0;
  - `ped_walk`=0, `phase`=0, pedestrian latch cleared.
- First `LOAD` happens in the first `CLK` edge after `reset` deasserts.
- All outputs are registered and change only on `CLK` rising edges.
- Lamp outputs switch in the `LOAD` cycle of the new phase, i.e. 1 cycle after `tmr_finished` is seen in `RUN`.
- Phase duration = timer expiry time + 2 cycles (`LOAD` + `ARM`) + 1 cycle of detection.
- Priority, per cycle: reset > `flash` change > `tmr_finished`.
- If `tmr_finished` and a `flash` rise coincide, `FLASH` wins.
- Reset mid-phase restarts at `START`. There is no partial-phase resume.

## Configuration
- `PED_REQUEST_EN` defined:
  - `ped_req`=1 sets a request latch.
  - On the `tmr_finished` that ends `NS_CLEAR` or `EW_CLEAR`, a set latch causes `WALK` (`T_WALK`) to be inserted before the next GREEN.
  - The latch clears on `WALK`/`LOAD`. A request during `WALK` re-latches for the next clearance.
  - `FLASH` clears the latch.
- `PED_REQUEST_EN` undefined: `ped_req` is ignored, `ped_walk` is tied to 0, and `WALK` is unreachable.

## Structure
- Shared package `traffic_pkg` holds:
  - the phase code constants (4 bit);
  - the sub-state codes;
  - the lamp encodings `LIGHT_RED`=3'b100, `LIGHT_YEL`=3'b010, `LIGHT_GRN`=3'b001, `LIGHT_OFF`=3'b000;
  - the 16-bit duration width.
- One sub-module, `ped_request_latch`: set/clear latch with asynchronous active-low reset. It is instantiated only under `PED_REQUEST_EN`.

## Test plan
Benches use the real `time_fsm`, or a model that pulses `finished` N seconds after `enable`. Parameters for all scenarios: `T_GREEN_NS`=2, `T_GREEN_EW`=2, `T_YELLOW`=1, `T_CLEAR`=1, `T_WALK`=1.
1. Reset release, free run -> order `START`, NS_G, NS_Y, NS_CLR, EW_G, EW_Y, EW_CLR, NS_G.
   - `tmr_seconds` reads 1, 2, 1, 1, 2, 1, 1, 2.
   - Lamp codes are exact per phase.
2. Watch `tmr_finished` in `ARM` -> it is ignored. Expiry in `RUN` -> the next phase's `LOAD` comes 1 cycle later.
3. `flash`=1 during `NS_GREEN`/`RUN` -> next cycle is `FLASH`/`LOAD` with `tmr_seconds`=1.
   - Lamps read 010/010, then 000/000, alternating each expiry.
   - `flash`=0 -> `START`.
4. `PED_REQUEST_EN`, `ped_req` pulsed during EW_G -> `WALK` inserted after EW_CLR with `ped_walk`=1 for 1 s, then NS_G.
   - Without the macro: no `WALK`, `ped_walk`=0.
5. `reset` asserted mid EW_Y -> outputs return to reset values immediately. Cycle restarts at `START`.
6. `T_YELLOW`=0 -> the yellow phase lasts 3 cycles and does not hang.
